// File: rtl/wmem_lookup_req.sv
// Read client for the wide BRAM app port. It issues tagged lookups, tracks the tags in flight
// and returns {tag, data} through a first-word-fall-through response FIFO.
module wmem_lookup_req #(
  parameter int unsigned WIDTH       = 40,
  parameter int unsigned DEPTH_NBITS = 10,
  parameter int unsigned TAG_NBITS   = 4,
  parameter int unsigned FIFO_NBITS  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  input  logic [DEPTH_NBITS-1:0] req_addr,
  input  logic [TAG_NBITS-1:0]   req_tag,
  output logic                   req_ready,
  output logic                   app_mem_rd,
  output logic [DEPTH_NBITS-1:0] app_mem_raddr,
  input  logic                   app_mem_ack,
  input  logic [WIDTH-1:0]       app_mem_rdata,
  output logic                   rsp_valid,
  output logic [TAG_NBITS-1:0]   rsp_tag,
  output logic [WIDTH-1:0]       rsp_data,
  input  logic                   rsp_ready,
  output logic [15:0]            lookup_cnt,
  output logic                   err_unexp_ack
);

  localparam int unsigned D = 1 << FIFO_NBITS;
  localparam logic [FIFO_NBITS+1:0] D_CREDITS = (FIFO_NBITS+2)'(D);

  logic [FIFO_NBITS:0]   in_flight, count;
  logic [FIFO_NBITS-1:0] tq_wr, tq_rd, df_wr, df_rd;
  logic [TAG_NBITS-1:0]  tag_q   [D];
  logic [TAG_NBITS-1:0]  df_tag  [D];
  logic [WIDTH-1:0]      df_data [D];
  logic                  accept, ack_ok, pop;

  // A credit is held from issue until the response is popped, so an ack always finds a free slot.
  assign req_ready = ({1'b0, in_flight} + {1'b0, count}) < D_CREDITS;
  assign accept    = req_valid & req_ready;
  assign ack_ok    = app_mem_ack & (in_flight != '0);
  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_tag   = rsp_valid ? df_tag[df_rd]  : '0;
  assign rsp_data  = rsp_valid ? df_data[df_rd] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      app_mem_rd    <= 1'b0;
      app_mem_raddr <= '0;
      lookup_cnt    <= '0;
      err_unexp_ack <= 1'b0;
      in_flight     <= '0;
      count         <= '0;
      tq_wr         <= '0;
      tq_rd         <= '0;
      df_wr         <= '0;
      df_rd         <= '0;
      for (int unsigned i = 0; i < D; i++) begin
        tag_q[i]   <= '0;
        df_tag[i]  <= '0;
        df_data[i] <= '0;
      end
    end else begin
      app_mem_rd <= accept;
      if (accept) begin
        app_mem_raddr <= req_addr;
        tag_q[tq_wr]  <= req_tag;
        tq_wr         <= tq_wr + FIFO_NBITS'(1);
        lookup_cnt    <= lookup_cnt + 16'd1;
      end
      if (ack_ok) begin
        df_tag[df_wr]  <= tag_q[tq_rd];
        df_data[df_wr] <= app_mem_rdata;
        df_wr          <= df_wr + FIFO_NBITS'(1);
        tq_rd          <= tq_rd + FIFO_NBITS'(1);
      end
      if (app_mem_ack && (in_flight == '0))
        err_unexp_ack <= 1'b1;
      if (pop)
        df_rd <= df_rd + FIFO_NBITS'(1);
      in_flight <= in_flight + (FIFO_NBITS+1)'(accept) - (FIFO_NBITS+1)'(ack_ok);
      count     <= count + (FIFO_NBITS+1)'(ack_ok) - (FIFO_NBITS+1)'(pop);
    end
  end

endmodule

// File: tb/tb_wmem_lookup_req.sv
// Directed bench for wmem_lookup_req with a fixed-latency memory model (ack 3 cycles after the strobe)
// and a scoreboard that pairs accepted requests with popped responses.
module tb_wmem_lookup_req;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [3:0]  req_tag = '0;
  logic        req_ready;
  logic        app_mem_rd;
  logic [9:0]  app_mem_raddr;
  logic        app_mem_ack;
  logic [39:0] app_mem_rdata;
  logic        rsp_valid;
  logic [3:0]  rsp_tag;
  logic [39:0] rsp_data;
  logic        rsp_ready = 1'b0;
  logic [15:0] lookup_cnt;
  logic        err_unexp_ack;

  logic        inj_ack = 1'b0;
  logic        p1 = 1'b0, p2 = 1'b0, p3 = 1'b0;
  logic [9:0]  a1 = '0, a2 = '0, a3 = '0;
  logic [43:0] exp_q[$];
  logic [43:0] got_q[$];
  int unsigned rd_cnt = 0;
  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  wmem_lookup_req #(
    .WIDTH(40), .DEPTH_NBITS(10), .TAG_NBITS(4), .FIFO_NBITS(2)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_tag(req_tag), .req_ready(req_ready),
    .app_mem_rd(app_mem_rd), .app_mem_raddr(app_mem_raddr),
    .app_mem_ack(app_mem_ack), .app_mem_rdata(app_mem_rdata),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .lookup_cnt(lookup_cnt), .err_unexp_ack(err_unexp_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [39:0] mem_word(input logic [9:0] a);
    return 40'h12_3456_7895 + {30'd0, a};
  endfunction

  // Memory keeps no reset so that reads issued before a reset still return afterwards.
  always @(posedge clk) begin
    p1 <= app_mem_rd; a1 <= app_mem_raddr;
    p2 <= p1;         a2 <= a1;
    p3 <= p2;         a3 <= a2;
  end
  assign app_mem_ack   = p3 | inj_ack;
  assign app_mem_rdata = p3 ? mem_word(a3) : 40'hFF_FFFF_FFFF;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      got_q.delete();
    end else begin
      if (req_valid && req_ready) exp_q.push_back({req_tag, mem_word(req_addr)});
      if (rsp_valid && rsp_ready) got_q.push_back({rsp_tag, rsp_data});
      if (app_mem_rd) rd_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    int unsigned n, base;

    tick(); tick();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rd", app_mem_rd, 0);
    chk("rst_raddr", app_mem_raddr, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_tag", rsp_tag, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_cnt", lookup_cnt, 0);
    chk("rst_err", err_unexp_ack, 0);
    rst = 1'b0;
    tick();

    // Single lookup: accept at T, strobe at T+1, response at T+5.
    req_valid = 1'b1; req_addr = 10'h005; req_tag = 4'd3;
    tick();
    req_valid = 1'b0;
    chk("t1_rd", app_mem_rd, 1);
    chk("t1_raddr", app_mem_raddr, 10'h005);
    chk("t1_cnt", lookup_cnt, 1);
    tick();
    chk("t1_rd_pulse", app_mem_rd, 0);
    tick(); tick();
    chk("t1_rsp_early", rsp_valid, 0);
    tick();
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_tag", rsp_tag, 3);
    chk("t1_rsp_data", rsp_data, 40'h12_3456_789A);
    rsp_ready = 1'b1;
    tick();
    chk("t1_popped", rsp_valid, 0);

    // Burst of 8 with downstream always ready.
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_addr = 10'(i); req_tag = 4'(i);
      for (int k = 0; k < 20 && !req_ready; k++) tick();
      chk("burst_ready", req_ready, 1);
      tick();
    end
    req_valid = 1'b0;
    repeat (12) tick();
    chk("burst_cnt", lookup_cnt, 9);
    chk("burst_drained", rsp_valid, 0);
    chk("burst_rsp_count", got_q.size(), 9);

    // Backpressure: FIFO fills with 4 entries and no further reads issue.
    rsp_ready = 1'b0;
    base = rd_cnt;
    n = 0;
    req_valid = 1'b1; req_addr = 10'd20; req_tag = 4'd10;
    repeat (12) begin
      acc = req_ready;
      tick();
      if (acc) begin
        n++;
        req_addr = 10'(20 + n);
        req_tag  = 4'(10 + n);
      end
    end
    chk("bp_cnt", lookup_cnt, 13);
    chk("bp_rd_strobes", rd_cnt - base, 4);
    chk("bp_ready_low", req_ready, 0);
    chk("bp_rsp_valid", rsp_valid, 1);
    chk("bp_head_tag", rsp_tag, 10);
    rsp_ready = 1'b1;
    chk("bp_same_cycle_ready", req_ready, 0);
    tick();
    rsp_ready = 1'b0;
    chk("bp_ready_back", req_ready, 1);
    chk("bp_next_head", rsp_tag, 11);
    tick();
    req_valid = 1'b0;
    chk("bp_extra_rd", app_mem_rd, 1);
    chk("bp_extra_raddr", app_mem_raddr, 10'd24);
    chk("bp_extra_cnt", lookup_cnt, 14);
    chk("bp_ready_full", req_ready, 0);
    rsp_ready = 1'b1;
    repeat (10) tick();
    chk("bp_drained", rsp_valid, 0);
    chk("bp_ready_idle", req_ready, 1);

    // Accept + ack + pop in one cycle with count=2, in_flight=1.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 10'd30; req_tag = 4'd1; tick();
    req_addr = 10'd31; req_tag = 4'd2; tick();
    req_valid = 1'b0; tick();
    req_valid = 1'b1; req_addr = 10'd32; req_tag = 4'd3; tick();
    req_valid = 1'b0; tick(); tick(); tick();
    req_valid = 1'b1; req_addr = 10'd33; req_tag = 4'd4; rsp_ready = 1'b1;
    chk("sim_ack", app_mem_ack, 1);
    chk("sim_rsp_valid", rsp_valid, 1);
    chk("sim_head_tag", rsp_tag, 1);
    chk("sim_ready", req_ready, 1);
    tick();
    req_valid = 1'b0; rsp_ready = 1'b0;
    chk("sim_after_tag", rsp_tag, 2);
    chk("sim_after_data", rsp_data, mem_word(10'd31));
    chk("sim_after_ready", req_ready, 1);
    chk("sim_cnt", lookup_cnt, 18);

    // Random traffic, then drain and compare the scoreboard.
    for (int c = 0; c < 100; c++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_addr  = 10'($urandom_range(0, 1023));
      req_tag   = 4'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (20) tick();
    chk("sb_count", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk("sb_entry", got_q[i], exp_q[i]);
    chk("sb_idle_valid", rsp_valid, 0);
    chk("sb_idle_ready", req_ready, 1);

    // Unexpected ack with nothing in flight.
    chk("ua_err_before", err_unexp_ack, 0);
    inj_ack = 1'b1;
    tick();
    inj_ack = 1'b0;
    chk("ua_err_set", err_unexp_ack, 1);
    chk("ua_no_rsp", rsp_valid, 0);
    repeat (3) tick();
    chk("ua_err_sticky", err_unexp_ack, 1);
    chk("ua_no_rsp_later", rsp_valid, 0);

    // Reset with 3 reads in flight and 1 FIFO entry.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 10'd40; req_tag = 4'd5; tick();
    req_valid = 1'b0; tick();
    req_valid = 1'b1; req_addr = 10'd41; req_tag = 4'd6; tick();
    req_addr = 10'd42; req_tag = 4'd7; tick();
    req_addr = 10'd43; req_tag = 4'd8; tick();
    req_valid = 1'b0;
    chk("mr_fifo_entry", rsp_valid, 1);
    chk("mr_full", req_ready, 0);
    rst = 1'b1;
    #1;
    chk("mr_req_ready", req_ready, 1);
    chk("mr_rd", app_mem_rd, 0);
    chk("mr_raddr", app_mem_raddr, 0);
    chk("mr_rsp_valid", rsp_valid, 0);
    chk("mr_rsp_tag", rsp_tag, 0);
    chk("mr_rsp_data", rsp_data, 0);
    chk("mr_cnt", lookup_cnt, 0);
    chk("mr_err", err_unexp_ack, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("mr_stale_err", err_unexp_ack, 1);
    chk("mr_stale_no_rsp", rsp_valid, 0);
    chk("mr_stale_cnt", lookup_cnt, 0);
    repeat (5) tick();
    req_valid = 1'b1; req_addr = 10'd7; req_tag = 4'd9;
    tick();
    req_valid = 1'b0;
    repeat (4) tick();
    chk("mr_new_valid", rsp_valid, 1);
    chk("mr_new_tag", rsp_tag, 9);
    chk("mr_new_data", rsp_data, mem_word(10'd7));
    chk("mr_new_cnt", lookup_cnt, 1);
    chk("mr_err_kept", err_unexp_ack, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
